// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Shared constants and types for the 10-entry byte FIFO and its write-port
// arbiter (fifo_write_arbiter).
//
// Contents:
//   FIFO_DEPTH  - number of entries in the FIFO; also the longest burst a
//                 single grant may write.
//   DATA_WIDTH  - FIFO word width (rx_data).
//   BEAT_W      - width of the arbiter beat and idle counters.
//   STAT_W      - width of each per-requester accepted-word counter.
//   OWNER_W     - width of owner_id / last_owner (covers up to 8 requesters).
//   arb_state_e - arbiter state encoding (ARB_IDLE / ARB_BURST).
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEPTH = 10;
  localparam int DATA_WIDTH = 8;
  localparam int BEAT_W     = 4;
  localparam int STAT_W     = 16;
  localparam int OWNER_W    = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter_if
//
// Bundles the requester handshake and the FIFO write port that the arbiter
// sits between.
//
// Parameters:
//   NUM_REQ    - number of requesters (2..8)
//   DATA_WIDTH - word width
//
// Signals:
//   req_valid [NUM_REQ]            - requester i has a word; held until acked
//   req_last  [NUM_REQ]            - the presented word ends requester i's burst
//   req_data  [NUM_REQ*DATA_WIDTH] - requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack   [NUM_REQ]            - one-hot, word accepted this cycle
//   fifo_full                      - FIFO Full_Flag
//   rx_data   [DATA_WIDTH]         - write data into the FIFO
//   rx_irq                         - write strobe into the FIFO
//
// Modports:
//   master - the environment: requesters plus the FIFO status flag
//   slave  - the arbiter
// -----------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          fifo_full;
  logic [DATA_WIDTH-1:0]         rx_data;
  logic                          rx_irq;

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output fifo_full,
    input  req_ack,
    input  rx_data,
    input  rx_irq
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  fifo_full,
    output req_ack,
    output rx_data,
    output rx_irq
  );

endinterface : fifo_write_arbiter_if

// File: rtl/fifo_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin selector. Scans last_owner+1, last_owner+2, ...
// (modulo NUM_REQ) and returns the first requester whose valid bit is set.
// last_owner itself is scanned last, so it only wins when nobody else wants
// the port.
//
// Parameters:
//   NUM_REQ    - number of requesters (2..8)
//
// Ports:
//   valid      in  [NUM_REQ] request vector
//   last_owner in  [3]       most recent owner (lowest priority this round)
//   pick       out [3]       selected requester (0 when none valid)
//   any_valid  out           at least one valid bit set
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [OWNER_W-1:0] last_owner,
  output logic [OWNER_W-1:0] pick,
  output logic               any_valid
);

  // Walk the priority ring from lowest to highest priority so that the
  // final assignment is the requester closest after last_owner.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise an
    // all-zero valid vector would leave pick unassigned and infer a latch.
    pick      = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (valid[i] && (i == (int'(last_owner) + k) % NUM_REQ)) begin
          pick      = OWNER_W'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares the single write port (rx_data / rx_irq) of the 10-entry byte FIFO
// among NUM_REQ requesters in the rx_clock domain.
//
// Arbitration is round-robin and burst-atomic: once granted, a requester
// keeps the port until it presents a word with req_last, has written
// MAX_BURST words, or leaves req_valid low for IDLE_TIMEOUT consecutive
// cycles. Each grant costs one bubble cycle in IDLE. The write path in BURST
// is combinational, so the FIFO and the requester see the transfer at the
// same edge and fifo_full is never stale. A full FIFO stalls the owner
// without counting as idle; the grant is kept for as long as it stays full.
//
// Parameters:
//   NUM_REQ      - number of requesters (2..8)
//   DATA_WIDTH   - word width, matches the FIFO rx_data width
//   MAX_BURST    - maximum beats per grant (FIFO depth), at most 16
//   IDLE_TIMEOUT - idle cycles before a grant is revoked, at most 16
//
// Ports:
//   rx_clock     in   clock, all state changes on its rising edge
//   reset        in   synchronous, active-high reset
//   bus          if   fifo_write_arbiter_if.slave (requesters + FIFO port)
//   owner_id     out  [3] current or most recent owner
//   busy         out  high while a grant is held (state BURST)
//   burst_abort  out  one-cycle pulse after a grant is revoked by timeout
//
// Optional (macro FIFO_WRITE_ARB_STATS_EN):
//   stats_clear  in   synchronously zeroes all accept counters
//   accept_count out  [NUM_REQ*16] per-requester saturating counts of
//                     accepted words, packed like req_data
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int MAX_BURST    = fifo_pkg::FIFO_DEPTH,
  parameter int IDLE_TIMEOUT = 15
) (
  input  logic                         rx_clock,
  input  logic                         reset,
  fifo_write_arbiter_if.slave          bus,
  output logic [fifo_pkg::OWNER_W-1:0] owner_id,
  output logic                         busy,
  output logic                         burst_abort
`ifdef FIFO_WRITE_ARB_STATS_EN
  ,
  input  logic                                 stats_clear,
  output logic [NUM_REQ*fifo_pkg::STAT_W-1:0]  accept_count
`endif
);

  import fifo_pkg::*;

  localparam logic [0:0] ST_IDLE  = ARB_IDLE;
  localparam logic [0:0] ST_BURST = ARB_BURST;

  logic [0:0]            state;
  logic [OWNER_W-1:0]    last_owner;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BEAT_W-1:0]     idle_cnt;

  logic [OWNER_W-1:0]    pick;
  logic                  any_valid;

  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  accept;
  logic                  beat_done;
  logic                  idle_done;

  // ---------------------------------------------------------------------------
  // Next-owner selection (only consulted in IDLE)
  // ---------------------------------------------------------------------------
  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid      (bus.req_valid),
    .last_owner (last_owner),
    .pick       (pick),
    .any_valid  (any_valid)
  );

  // ---------------------------------------------------------------------------
  // Owner lane mux
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_id == OWNER_W'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_last  = bus.req_last[i];
        owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational write path
  // ---------------------------------------------------------------------------
  // A word presented during reset is never acked: the state is discarded at
  // that edge and the requester must present the word again.
  assign accept = (state == ST_BURST) && owner_valid && !bus.fifo_full && !reset;

  assign bus.rx_irq  = accept;
  assign bus.rx_data = accept ? owner_data : '0;
  assign busy        = (state == ST_BURST);

  always_comb begin
    bus.req_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && (owner_id == OWNER_W'(i))) begin
        bus.req_ack[i] = 1'b1;
      end
    end
  end

  // Terminal compares fire before either counter can wrap, so both stay in
  // range without explicit saturation.
  assign beat_done = owner_last || (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign idle_done = (idle_cnt == BEAT_W'(IDLE_TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // Arbiter state
  // ---------------------------------------------------------------------------
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner_id    <= '0;
      last_owner  <= OWNER_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      burst_abort <= 1'b0;
    end else begin
      burst_abort <= 1'b0;
      if (state == ST_IDLE) begin
        if (any_valid) begin
          owner_id <= pick;
          beat_cnt <= '0;
          idle_cnt <= '0;
          state    <= ST_BURST;
        end
      end else begin
        if (accept) begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
          idle_cnt <= '0;
          if (beat_done) begin
            state      <= ST_IDLE;
            last_owner <= owner_id;
          end
        end else if (!owner_valid) begin
          // A full-FIFO stall (owner valid, no accept) is not idle time.
          idle_cnt <= idle_cnt + BEAT_W'(1);
          if (idle_done) begin
            state       <= ST_IDLE;
            last_owner  <= owner_id;
            burst_abort <= 1'b1;
          end
        end
      end
    end
  end

`ifdef FIFO_WRITE_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Per-requester accepted-word counters, sticking at all-ones
  // ---------------------------------------------------------------------------
  always_ff @(posedge rx_clock) begin
    if (reset || stats_clear) begin
      accept_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ack[i] && (accept_count[i*STAT_W +: STAT_W] != '1)) begin
          accept_count[i*STAT_W +: STAT_W] <= accept_count[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
    end
  end
`endif

endmodule : fifo_write_arbiter

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Self-checking bench for fifo_write_arbiter. Requesters are modelled as
// word queues: a requester is valid while its queue is non-empty and its head
// pops when the reference model expects an ack. The reference model tracks
// who holds the port, how many beats and idle cycles the grant has used, and
// who owned it last; the round-robin choice is "first valid requester after
// the last owner". Every cycle all outputs are compared against the model,
// and each scenario checks its own externally visible properties (write
// order, data, timing gaps, abort pulses) against constants.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int NR      = 4;
  localparam int DW      = 8;
  localparam int MAXB    = 10;
  localparam int IDLE_TO = 15;

  logic          rx_clock;
  logic          reset;
  logic [2:0]    owner_id;
  logic          busy;
  logic          burst_abort;
`ifdef FIFO_WRITE_ARB_STATS_EN
  logic             stats_clear;
  logic [NR*16-1:0] accept_count;
`endif

  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .MAX_BURST    (MAXB),
    .IDLE_TIMEOUT (IDLE_TO)
  ) dut (
    .rx_clock    (rx_clock),
    .reset       (reset),
    .bus         (bus),
    .owner_id    (owner_id),
    .busy        (busy),
    .burst_abort (burst_abort)
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    .stats_clear  (stats_clear),
    .accept_count (accept_count)
`endif
  );

  initial rx_clock = 1'b0;
  always #5 rx_clock = ~rx_clock;

  // Requester word queues: {last, data}
  logic [DW:0] q [NR][$];

  // Reference model
  bit m_busy;
  int m_owner;
  int m_last;
  int m_beats;
  int m_idle;
  bit m_abort;

  // Observation logs
  int          log_cyc [$];
  int          log_own [$];
  logic [DW-1:0] log_dat [$];
  int          abort_cnt;
  int          abort_cyc;

  int cyc;
  int n_checks;
  int n_pass;

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_first(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic clear_logs();
    log_cyc.delete();
    log_own.delete();
    log_dat.delete();
  endtask

  // One clock cycle: drive requester lanes, compare outputs with the model,
  // log observed writes, advance the model. Entered and left at a negedge.
  task automatic cycle();
    logic [NR-1:0]      v;
    logic [DW-1:0]      hd;
    logic               hl;
    logic               acc;
    logic [NR-1:0]      ea;
    logic [DW+NR+5:0]   exp_v;
    logic [DW+NR+5:0]   got_v;
    bit                 nxt_abort;
    int                 w;
    v  = '0;
    hd = '0;
    hl = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() > 0) begin
        v[i] = 1'b1;
        bus.req_last[i] = q[i][0][DW];
        bus.req_data[i*DW +: DW] = q[i][0][DW-1:0];
      end else begin
        bus.req_last[i] = 1'($urandom_range(0, 1));
        bus.req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    bus.req_valid = v;
    if (v[m_owner]) begin
      hd = q[m_owner][0][DW-1:0];
      hl = q[m_owner][0][DW];
    end
    #1;
    acc = m_busy && v[m_owner] && !bus.fifo_full && !reset;
    ea = '0;
    if (acc) ea[m_owner] = 1'b1;
    exp_v = {acc, (acc ? hd : DW'(0)), ea, m_busy, 3'(m_owner), m_abort};
    got_v = {bus.rx_irq, bus.rx_data, bus.req_ack, busy, owner_id, burst_abort};
    n_checks++;
    if (got_v !== exp_v)
      $display("FAIL cycle %0d outputs {irq,data,ack,busy,owner,abort}: got %h expected %h",
               cyc, got_v, exp_v);
    else
      n_pass++;
    if (bus.rx_irq === 1'b1) begin
      log_cyc.push_back(cyc);
      log_own.push_back(int'(owner_id));
      log_dat.push_back(bus.rx_data);
    end
    if (burst_abort === 1'b1) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    nxt_abort = 1'b0;
    if (reset) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = NR - 1;
    end else if (!m_busy) begin
      w = rr_first(v, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_busy  = 1'b1;
        m_beats = 0;
        m_idle  = 0;
      end
    end else if (acc) begin
      void'(q[m_owner].pop_front());
      m_beats++;
      m_idle = 0;
      if (hl || m_beats == MAXB) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end else if (!v[m_owner]) begin
      m_idle++;
      if (m_idle == IDLE_TO) begin
        m_busy    = 1'b0;
        m_last    = m_owner;
        nxt_abort = 1'b1;
      end
    end
    m_abort = nxt_abort;
    @(negedge rx_clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain(int max_cycles, string name);
    int n;
    n = 0;
    while ((pending() || m_busy) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) begin
      n_checks++;
      $display("FAIL %s drain: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic run_until_writes(int target, int max_cycles, string name);
    int n;
    n = 0;
    while (log_cyc.size() < target && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) begin
      n_checks++;
      $display("FAIL %s wait: %0d writes seen, required %0d", name, log_cyc.size(), target);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (bus.rx_irq !== 1'b0) $display("FAIL reset rx_irq: got %b expected 0", bus.rx_irq); else n_pass++;
    n_checks++; if (bus.req_ack !== 4'b0000) $display("FAIL reset req_ack: got %b expected 0000", bus.req_ack); else n_pass++;
    n_checks++; if (owner_id !== 3'd0) $display("FAIL reset owner_id: got %0d expected 0", owner_id); else n_pass++;
    n_checks++; if (burst_abort !== 1'b0) $display("FAIL reset burst_abort: got %b expected 0", burst_abort); else n_pass++;
    n_checks++; if (bus.rx_data !== 8'h00) $display("FAIL reset rx_data: got %h expected 00", bus.rx_data); else n_pass++;
  endtask

  task automatic test_single_burst();
    int c0;
    clear_logs();
    c0 = cyc;
    q[0].push_back({1'b0, 8'h11});
    q[0].push_back({1'b0, 8'h22});
    q[0].push_back({1'b1, 8'h33});
    drain(50, "single_burst");
    n_checks++;
    if (log_cyc.size() !== 3) $display("FAIL single_burst writes: got %0d expected 3", log_cyc.size());
    else begin
      n_pass++;
      n_checks++; if (log_cyc[0] !== c0 + 1) $display("FAIL single_burst first write cycle: got %0d expected %0d", log_cyc[0], c0 + 1); else n_pass++;
      n_checks++; if (log_cyc[2] - log_cyc[0] !== 2) $display("FAIL single_burst contiguity: got span %0d expected 2", log_cyc[2] - log_cyc[0]); else n_pass++;
      n_checks++; if ({log_dat[0], log_dat[1], log_dat[2]} !== 24'h112233) $display("FAIL single_burst data: got %h%h%h expected 112233", log_dat[0], log_dat[1], log_dat[2]); else n_pass++;
    end
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_burst release busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_rotation();
    do_reset();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        q[i].push_back({1'b1, 8'(8'h40 + r * 4 + i)});
    drain(100, "rotation");
    n_checks++;
    if (log_cyc.size() !== 8) $display("FAIL rotation writes: got %0d expected 8", log_cyc.size());
    else begin
      n_pass++;
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (log_own[k] !== k % NR || log_dat[k] !== 8'(8'h40 + k))
          $display("FAIL rotation write %0d: got owner %0d data %h expected owner %0d data %h",
                   k, log_own[k], log_dat[k], k % NR, 8'(8'h40 + k));
        else n_pass++;
        if (k > 0) begin
          n_checks++;
          if (log_cyc[k] - log_cyc[k-1] !== 2)
            $display("FAIL rotation gap %0d: got %0d cycles expected 2", k, log_cyc[k] - log_cyc[k-1]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_max_burst();
    int eo;
    logic [7:0] ed;
    do_reset();
    clear_logs();
    for (int j = 0; j < 12; j++) q[2].push_back({(j == 11), 8'(8'h80 + j)});
    for (int j = 0; j < 3; j++) cycle();
    q[3].push_back({1'b1, 8'hC3});
    drain(100, "max_burst");
    n_checks++;
    if (log_cyc.size() !== 13) $display("FAIL max_burst writes: got %0d expected 13", log_cyc.size());
    else begin
      n_pass++;
      for (int k = 0; k < 13; k++) begin
        if (k < 10) begin eo = 2; ed = 8'(8'h80 + k); end
        else if (k == 10) begin eo = 3; ed = 8'hC3; end
        else begin eo = 2; ed = 8'(8'h80 + k - 1); end
        n_checks++;
        if (log_own[k] !== eo || log_dat[k] !== ed)
          $display("FAIL max_burst write %0d: got owner %0d data %h expected owner %0d data %h",
                   k, log_own[k], log_dat[k], eo, ed);
        else n_pass++;
      end
      n_checks++;
      if (log_cyc[10] - log_cyc[9] !== 2)
        $display("FAIL max_burst release gap: got %0d expected 2", log_cyc[10] - log_cyc[9]);
      else n_pass++;
    end
  endtask

  task automatic test_full_stall();
    int ab0;
    int cf;
    do_reset();
    clear_logs();
    for (int j = 0; j < 6; j++) q[1].push_back({(j == 5), 8'(8'h60 + j)});
    run_until_writes(4, 30, "full_stall");
    bus.fifo_full = 1'b1;
    ab0 = abort_cnt;
    for (int j = 0; j < 20; j++) cycle();
    n_checks++; if (log_cyc.size() !== 4) $display("FAIL full_stall writes while full: got %0d expected 4", log_cyc.size()); else n_pass++;
    n_checks++; if (abort_cnt !== ab0) $display("FAIL full_stall abort: got %0d pulses expected 0", abort_cnt - ab0); else n_pass++;
    bus.fifo_full = 1'b0;
    cf = cyc;
    drain(50, "full_stall");
    n_checks++;
    if (log_cyc.size() !== 6) $display("FAIL full_stall total writes: got %0d expected 6", log_cyc.size());
    else begin
      n_pass++;
      n_checks++;
      if (log_cyc[4] !== cf || log_dat[4] !== 8'h64)
        $display("FAIL full_stall resume: got cycle %0d data %h expected cycle %0d data 64", log_cyc[4], log_dat[4], cf);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int ab0;
    do_reset();
    clear_logs();
    ab0 = abort_cnt;
    q[0].push_back({1'b0, 8'h01});
    q[0].push_back({1'b0, 8'h02});
    q[1].push_back({1'b1, 8'hB1});
    drain(100, "timeout");
    n_checks++; if (abort_cnt - ab0 !== 1) $display("FAIL timeout abort pulses: got %0d expected 1", abort_cnt - ab0); else n_pass++;
    n_checks++;
    if (log_cyc.size() !== 3) $display("FAIL timeout writes: got %0d expected 3", log_cyc.size());
    else begin
      n_pass++;
      n_checks++; if (abort_cyc !== log_cyc[1] + 16) $display("FAIL timeout abort cycle: got %0d expected %0d", abort_cyc, log_cyc[1] + 16); else n_pass++;
      n_checks++;
      if (log_own[2] !== 1 || log_cyc[2] !== abort_cyc + 1)
        $display("FAIL timeout regrant: got owner %0d cycle %0d expected owner 1 cycle %0d", log_own[2], log_cyc[2], abort_cyc + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    clear_logs();
    for (int j = 0; j < 5; j++) q[0].push_back({(j == 4), 8'(8'h20 + j)});
    for (int i = 1; i < NR; i++) q[i].push_back({1'b1, 8'(8'h30 + i)});
    run_until_writes(2, 20, "reset_mid");
    n0 = log_cyc.size();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (log_cyc.size() !== n0) $display("FAIL reset_mid write during reset: got %0d writes expected %0d", log_cyc.size(), n0); else n_pass++;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_mid busy after reset: got %b expected 0", busy); else n_pass++;
    n_checks++; if (bus.rx_irq !== 1'b0) $display("FAIL reset_mid rx_irq after reset: got %b expected 0", bus.rx_irq); else n_pass++;
    drain(60, "reset_mid");
    n_checks++;
    if (log_cyc.size() !== n0 + 6) $display("FAIL reset_mid writes: got %0d expected %0d", log_cyc.size(), n0 + 6);
    else begin
      n_pass++;
      n_checks++;
      if (log_own[n0] !== 0 || log_dat[n0] !== 8'h22)
        $display("FAIL reset_mid first winner: got owner %0d data %h expected owner 0 data 22", log_own[n0], log_dat[n0]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int pushed;
    int r;
    int len;
    bit lst;
    do_reset();
    clear_logs();
    pushed = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, NR - 1);
        if (q[r].size() < 20) begin
          len = $urandom_range(1, 12);
          lst = ($urandom_range(0, 3) != 0);
          for (int j = 0; j < len; j++) q[r].push_back({(lst && j == len - 1), DW'($urandom)});
          pushed += len;
        end
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      cycle();
    end
    bus.fifo_full = 1'b0;
    drain(2000, "random");
    n_checks++;
    if (log_cyc.size() !== pushed) $display("FAIL random total writes: got %0d expected %0d", log_cyc.size(), pushed);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
`ifdef FIFO_WRITE_ARB_STATS_EN
    stats_clear   = 1'b0;
`endif
    m_busy    = 1'b0;
    m_owner   = 0;
    m_last    = NR - 1;
    m_beats   = 0;
    m_idle    = 0;
    m_abort   = 1'b0;
    abort_cnt = 0;
    abort_cyc = -1;
    cyc       = 0;
    n_checks  = 0;
    n_pass    = 0;
    @(negedge rx_clock);

    test_reset();
    test_single_burst();
    test_rotation();
    test_max_burst();
    test_full_stall();
    test_timeout();
    test_reset_mid();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fifo_write_arbiter

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port (rx_data/rx_irq) of the 10-entry byte FIFO among NUM_REQ requesters, in the rx_clock domain.
- Arbitration is round-robin and burst-atomic: a granted requester keeps the port until its last beat, MAX_BURST beats, or an idle timeout.
- Honours the FIFO Full_Flag so no write is ever issued to a full FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, data word width; matches the FIFO rx_data width
- MAX_BURST, 10, maximum beats per grant (equals FIFO depth)
- IDLE_TIMEOUT, 15, consecutive cycles the owner may hold req_valid low mid-burst before the grant is revoked

Ports:
- rx_clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of rx_clock
- req_valid  in  NUM_REQ  per-requester word available; held until acked
- req_last  in  NUM_REQ  per-requester flag: the presented word ends the burst
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_full  in  1  FIFO Full_Flag
- rx_data  out  DATA_WIDTH  write data to the FIFO
- rx_irq  out  1  write strobe to the FIFO
- req_ack  out  NUM_REQ  one-hot; word accepted this cycle
- owner_id  out  3  index of the current or most recent owner
- busy  out  1  high while in state BURST
- burst_abort  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- States: IDLE, BURST. Registers: state, owner_id, beat_cnt (4b), idle_cnt (4b), last_owner.
- Reset values: state=IDLE, owner_id=0, last_owner=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0, idle_cnt=0, burst_abort=0.
- Outputs after reset: rx_irq=0, req_ack=0, busy=0; rx_data=0 whenever rx_irq=0.
- IDLE:
  - If any req_valid is high, select the first valid requester scanning last_owner+1, last_owner+2, … modulo NUM_REQ.
  - Register it as owner_id, clear beat_cnt and idle_cnt, and go to BURST.
  - This costs a one-cycle bubble per grant. No writes are issued in IDLE.
- BURST, combinational write path:
  - accept = req_valid[owner_id] & !fifo_full.
  - rx_irq = accept; rx_data = req_data[owner_id]; req_ack[owner_id] = accept.
  - Zero latency: the FIFO and the requester both see the transfer at the same edge, so Full_Flag is never stale.
- On accept:
  - beat_cnt increments and idle_cnt clears.
  - If req_last[owner_id]=1 or beat_cnt==MAX_BURST-1: go to IDLE and set last_owner=owner_id.
- Owner req_valid low (no accept):
  - idle_cnt increments.
  - When idle_cnt==IDLE_TIMEOUT-1: go to IDLE, set last_owner=owner_id, and pulse burst_abort (registered, high the cycle after the transition edge).
- fifo_full high with the owner valid:
  - Stall with no ack and no write. This is not idle, so idle_cnt holds.
  - The grant is kept indefinitely.
- Requesters not owning the port: req_ack stays 0 regardless of their req_valid.
- Reset asserted mid-burst: return to IDLE at that edge. An in-flight word is not acked and the requester must re-present it.
- Width rules:
  - beat_cnt and idle_cnt saturate by construction; the terminal compares fire first.
  - Upper bits of owner_id are 0 when NUM_REQ<8.

Optional Feature:
- Macro: FIFO_WRITE_ARB_STATS_EN.
- When defined:
  - Adds output accept_count, NUM_REQ*16 bits, packed the same way as req_data.
  - Holds per-requester 16-bit saturating counters of accepted words.
  - Counters are cleared by reset, increment on req_ack[i], and stick at 16'hFFFF.
  - Adds input stats_clear, which zeroes all counters synchronously; stats_clear has priority over an increment in the same cycle.
- When undefined: neither port exists and no counters are built. Write-path behaviour is identical either way.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_DEPTH=10 and DATA_WIDTH=8;
  - a state enum, ARB_IDLE=1'b0 and ARB_BURST=1'b1;
  - counter width constants BEAT_W=4 and STAT_W=16.
- One natural sub-module: rr_pick. It is a combinational round-robin selector taking the valid vector and last_owner, and returning the selected index plus an any_valid flag.

Test Plan:
- After reset, req_valid=4'b0001 with a 3-beat burst (0x11, 0x22, 0x33; last on 0x33) and fifo_full=0 -> busy from cycle 2, rx_irq on 3 consecutive cycles with data 0x11, 0x22, 0x33, then IDLE, last_owner=0.
- req_valid=4'b1111 held, every burst 1 beat with last set -> grants rotate 0,1,2,3,0 with one bubble cycle between writes.
- Requester 2 streams 12 beats with no last -> 10 writes, forced release to IDLE after beat 10; another valid requester is granted next and requester 2 regains the port later with beats 11-12.
- Owner writes 4 beats, fifo_full asserts for 20 cycles, then deasserts -> no rx_irq and no ack during full, no burst_abort, and the 5th beat is written on the first non-full cycle.
- Owner drops req_valid after 2 beats -> burst_abort pulses exactly once after 15 idle cycles and the next valid requester is granted.
- Reset asserted in the middle of a burst -> rx_irq=0 and busy=0 on the next cycle; after reset deasserts, requester 0 wins when all requesters are valid.
